// File: rtl/step_plot.sv
// Step-path walker: emits moto, moto+/-1, ... for sa+1 beats on a valid/ready stream.
// Define STEP_PLOT_CLIP_EN to saturate at 0/1023 and raise a sticky clip flag instead of wrapping.
module step_plot (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       in_do,
  input  logic [9:0] moto,
  input  logic [9:0] sa,
  input  logic       neg,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [9:0] pos,
  output logic       last,
  output logic       busy,
  output logic       clip
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] rst_sync;
  logic [9:0] pos_q;
  logic [9:0] pos_step;
  logic [9:0] remaining;
  logic       dir;
  logic       accept;
  logic       xfer;
  logic       step_en;

  // Reset asserts asynchronously everywhere; starts are held off until release has crossed into m_clock.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign accept  = (state == IDLE) && in_do && rst_sync[1];
  assign xfer    = (state == RUN) && out_ready;
  assign step_en = xfer && (remaining != '0);

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (xfer && (remaining == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == RUN);
    busy      = (state == RUN);
    last      = (state == RUN) && (remaining == '0);
  end

`ifdef STEP_PLOT_CLIP_EN
  logic sat;
  logic clip_q;

  always_comb begin
    pos_step = pos_q;
    sat      = 1'b0;
    if (dir) begin
      if (pos_q == '0) sat = 1'b1;
      else             pos_step = pos_q - 10'd1;
    end else begin
      if (pos_q == '1) sat = 1'b1;
      else             pos_step = pos_q + 10'd1;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset)              clip_q <= 1'b0;
    else if (accept)           clip_q <= 1'b0;
    else if (step_en && sat)   clip_q <= 1'b1;
  end

  assign clip = clip_q;
`else
  always_comb begin
    pos_step = dir ? (pos_q - 10'd1) : (pos_q + 10'd1);
  end

  assign clip = 1'b0;
`endif

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      pos_q     <= '0;
      remaining <= '0;
      dir       <= 1'b0;
    end else if (accept) begin
      pos_q     <= moto;
      remaining <= sa;
      dir       <= neg;
    end else if (step_en) begin
      pos_q     <= pos_step;
      remaining <= remaining - 10'd1;
    end
  end

  assign pos = pos_q;

endmodule

// File: doc/step_plot.md
STEP_PLOT -- requirements
Module: step_plot

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port: m_clock  input  1  rising-edge clock for all state.
REQ-003 Port: p_reset  input  1  asynchronous reset, active-low.
REQ-004 Port: in_do  input  1  start strobe, one cycle, sampled only in IDLE.
REQ-005 Port: moto  input  10  start coordinate (unsigned), captured on accepted in_do.
REQ-006 Port: sa  input  10  step magnitude (unsigned distance), captured on accepted in_do.
REQ-007 Port: neg  input  1  direction: 0 = increment, 1 = decrement; captured on accepted in_do.
REQ-008 Port: out_ready  input  1  downstream accepts current beat.
REQ-009 Port: out_valid  output  1  pos/last hold a valid beat.
REQ-010 Port: pos  output  10  current path coordinate.
REQ-011 Port: last  output  1  current beat is the final one.
REQ-012 Port: busy  output  1  walk in progress (state RUN).
REQ-013 Port: clip  output  1  sticky range-limit flag; only when STEP_PLOT_CLIP_EN is defined, otherwise tied 0.

Function
REQ-014 Two states, IDLE and RUN: IDLE->RUN on in_do, and RUN->IDLE on the accepted beat with last=1.
REQ-015 Accepted in_do in IDLE SHALL load pos=moto and remaining=sa, and SHALL assert out_valid and busy on the next cycle (1-cycle latency).
REQ-016 A beat transfers when out_valid=1 and out_ready=1 in the same cycle.
REQ-017 last SHALL equal (remaining==0) while out_valid=1, and SHALL be 0 otherwise.
REQ-018 On a transfer with last=0: pos <= pos+1 (neg=0) or pos-1 (neg=1), remaining <= remaining-1, with no bubble between beats.
REQ-019 A walk SHALL emit exactly sa+1 beats, the first being moto; sa=0 gives a single beat with last=1.
REQ-020 While out_valid=1 and out_ready=0, pos, last and remaining SHALL hold stable.
REQ-021 in_do while busy=1 SHALL be ignored, and captured moto/sa/neg SHALL be unaffected.
REQ-022 After the final transfer, out_valid=0 and busy=0 SHALL hold on the next cycle, and a new in_do SHALL be accepted that same cycle.
REQ-023 All arithmetic SHALL be 10-bit unsigned, and remaining SHALL never underflow.

Reset
REQ-024 p_reset low SHALL asynchronously force IDLE with out_valid=0, busy=0, last=0, pos=0, remaining=0 and clip=0.
REQ-025 Reset asserted mid-walk SHALL abort the walk immediately, and no beat SHALL be emitted after release until a new in_do.
REQ-026 Reset deassertion SHALL be synchronised to m_clock before leaving IDLE.

Configuration
REQ-027 Macro STEP_PLOT_CLIP_EN SHALL select edge handling.
REQ-028 Without STEP_PLOT_CLIP_EN, pos SHALL wrap modulo 1024 (1023+1=0, 0-1=1023) and clip SHALL be constant 0.
REQ-029 With STEP_PLOT_CLIP_EN, pos SHALL saturate at 0 or 1023 while the beat count stays sa+1.
REQ-030 With STEP_PLOT_CLIP_EN, the first saturated step SHALL set clip, which stays set until the next accepted in_do clears it.

Verification
REQ-031 moto=5, sa=3, neg=0, out_ready=1 -> pos 5,6,7,8 on consecutive cycles, last only with 8, busy=0 the cycle after.
REQ-032 moto=5, sa=3, neg=1 -> pos 5,4,3,2, with last on 2.
REQ-033 moto=700, sa=0 -> single beat pos=700, last=1, then IDLE.
REQ-034 moto=10, sa=3, out_ready low 2 cycles while pos=11 -> pos=11 held 3 cycles, sequence 10,11,12,13, no skips or duplicates.
REQ-035 moto=1022, sa=3, neg=0 -> without macro 1022,1023,0,1 and clip=0; with macro 1022,1023,1023,1023 and clip=1 from the third beat.
REQ-036 p_reset low mid-walk, plus in_do pulsed while busy -> outputs zero without a clock edge, the busy-time in_do produces no new walk, and a post-reset in_do starts cleanly.
